// File: rtl/bc_pkg.sv
// Shared types and default sizing for the CPU/DMA memory arbiter.
package bc_pkg;

    // Arbiter state: who owned the memory port in the previous cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no grant last cycle
        ST_CPU  = 2'd1,  // CPU granted last cycle
        ST_DMA  = 2'd2,  // DMA granted last cycle (unlocked)
        ST_LOCK = 2'd3   // DMA holds the bus for a locked burst
    } bc_state_t;

    localparam int BC_ADDR_W       = 12;
    localparam int BC_DATA_W       = 16;
    localparam int BC_STARVE_LIMIT = 4;

endpackage

// File: rtl/bc_starve_cnt.sv
// Saturating count of consecutive cycles the DMA has waited without a grant.
module bc_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,      // DMA valid and not accepted this cycle
    input  logic clr,      // DMA accepted or not requesting
    output logic starved   // count has reached LIMIT
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_reg;

    // Count waiting cycles, holding at LIMIT; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != LIMIT_V)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign starved = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/bc_mem_arbiter.sv
// Single-port memory arbiter between the CPU controller and a DMA/loader.
// Grants are combinational in the request cycle; read data comes back one
// cycle later, routed only to the requester that issued the read.
module bc_mem_arbiter
    import bc_pkg::*;
#(
    parameter int STARVE_LIMIT = BC_STARVE_LIMIT,
    parameter int ADDR_W       = BC_ADDR_W,
    parameter int DATA_W       = BC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    // DMA side
    input  logic              dma_valid,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    // Memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    bc_state_t         state_reg, state_next;
    logic              starved;
    logic              lock_hold;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              rd_cpu_reg, rd_dma_reg;

    // The lock only persists while the DMA keeps dma_lock asserted; the first
    // cycle it drops, normal arbitration applies in that same cycle.
    assign lock_hold = (state_reg == ST_LOCK) && dma_lock;

    bc_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (dma_valid & ~dma_ready),
        .clr     (~dma_valid | dma_ready),
        .starved (starved)
    );

    // Arbitration and next state: CPU first unless the DMA is starved or the
    // DMA holds the bus. No grants at all while reset is asserted.
    always_comb begin
        cpu_gnt    = 1'b0;
        dma_ready  = 1'b0;
        state_next = state_reg;
        if (!rst) begin
            if (lock_hold) begin
                dma_ready = dma_valid;
            end else if (dma_valid && (starved || !cpu_req)) begin
                dma_ready = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
            end
        end
        if (lock_hold) begin
            state_next = ST_LOCK;
        end else if (dma_ready) begin
            state_next = dma_lock ? ST_LOCK : ST_DMA;
        end else if (cpu_gnt) begin
            state_next = ST_CPU;
        end else begin
            state_next = ST_IDLE;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory port mux: the granted requester drives the port; with no grant
    // the address and data hold their last granted values.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        if (dma_ready) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Remember the last driven address/data so an idle port does not toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (cpu_gnt || dma_ready) begin
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
        end
    end

    // Track which requester owns the read data arriving next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cpu_reg <= 1'b0;
            rd_dma_reg <= 1'b0;
        end else begin
            rd_cpu_reg <= cpu_gnt & ~cpu_we;
            rd_dma_reg <= dma_ready & ~dma_we;
        end
    end

    assign cpu_rvalid = rd_cpu_reg;
    assign dma_rvalid = rd_dma_reg;
    assign cpu_rdata  = rd_cpu_reg ? mem_rdata : '0;
    assign dma_rdata  = rd_dma_reg ? mem_rdata : '0;

endmodule
